// File: rtl/sub_pipe32.sv
// sub_pipe32 -- pipelined WIDTH-bit subtractor/comparator with valid/ready
// handshake on both sides. Computes x - y - bin as x + ~y + ~bin, and
// produces borrow-out plus zero/neg/ovf/lts flags.
// The pipeline has LATENCY register stages. Results are visible LATENCY
// cycles after the cycle in which the op is accepted.
// When LATENCY >= 2, the low half of the borrow chain is resolved in stage 0
// and the high half in stage 1. With LATENCY == 1, the whole chain resolves
// in a single stage.
// Optional feature: define SUB_PIPE_OCC_EN to add the 4-bit 'occ' output,
// which counts the ops in flight.
module sub_pipe32 #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             neg,
  output logic             ovf,
  output logic             lts
`ifdef SUB_PIPE_OCC_EN
  ,
  output logic [3:0]       occ
`endif
);

  localparam int RW    = WIDTH + 5;
  localparam int FIRST = (LATENCY == 1) ? 0 : 1;

  function automatic logic [RW-1:0] pack_result(input logic [WIDTH-1:0] d,
                                                input logic carry,
                                                input logic x_msb,
                                                input logic y_msb);
    logic b, z, n, o, l;
    b = ~carry;
    z = ~|d;
    n = d[WIDTH-1];
    o = (x_msb != y_msb) && (n != x_msb);
    l = n ^ o;
    return {d, b, z, n, o, l};
  endfunction

  logic               stall;
  logic               accept;
  logic [LATENCY-1:0] valid_q, valid_d;
  logic [RW-1:0]      res_q [LATENCY];
  logic [RW-1:0]      res_d [LATENCY];
  logic [RW-1:0]      first_res;
  logic               first_load;

  assign stall    = valid_q[LATENCY-1] && !out_ready;
  assign in_ready = !stall;
  assign accept   = in_valid && in_ready;

  generate
    if (LATENCY == 1) begin : g_single
      logic [WIDTH-1:0] d_full;
      logic             c_full;

      assign {c_full, d_full} = {1'b0, x} + {1'b0, ~y} + {{WIDTH{1'b0}}, ~bin};
      assign first_res  = pack_result(d_full, c_full, x[WIDTH-1], y[WIDTH-1]);
      assign first_load = accept;
    end else begin : g_split
      localparam int LO = WIDTH / 2;
      localparam int HI = WIDTH - LO;

      logic [LO-1:0] lo_sum_d, lo_sum_q;
      logic          lo_c_d, lo_c_q;
      logic [HI-1:0] x_hi_d, x_hi_q;
      logic [HI-1:0] ny_hi_d, ny_hi_q;
      logic [HI-1:0] hi_sum;
      logic          hi_c;

      // Resolve the low-half borrow chain at acceptance and capture the upper operand halves
      always_comb begin
        lo_sum_d = lo_sum_q;
        lo_c_d   = lo_c_q;
        x_hi_d   = x_hi_q;
        ny_hi_d  = ny_hi_q;
        if (accept) begin
          {lo_c_d, lo_sum_d} = {1'b0, x[LO-1:0]} + {1'b0, ~y[LO-1:0]} + {{LO{1'b0}}, ~bin};
          x_hi_d  = x[WIDTH-1:LO];
          ny_hi_d = ~y[WIDTH-1:LO];
        end
      end

      // Stage 0 partial-result registers only load on accept, so idle X/Z operands never enter
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          lo_sum_q <= '0;
          lo_c_q   <= 1'b0;
          x_hi_q   <= '0;
          ny_hi_q  <= '0;
        end else begin
          lo_sum_q <= lo_sum_d;
          lo_c_q   <= lo_c_d;
          x_hi_q   <= x_hi_d;
          ny_hi_q  <= ny_hi_d;
        end
      end

      assign {hi_c, hi_sum} = {1'b0, x_hi_q} + {1'b0, ny_hi_q} + {{HI{1'b0}}, lo_c_q};
      assign first_res  = pack_result({hi_sum, lo_sum_q}, hi_c, x_hi_q[HI-1], ~ny_hi_q[HI-1]);
      assign first_load = valid_q[0];
    end
  endgenerate

  // Advance all stages together unless the output is stalled; bubbles carry valid=0
  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < LATENCY; i++) res_d[i] = res_q[i];
    if (!stall) begin
      valid_d[0] = accept;
      for (int i = 1; i < LATENCY; i++) valid_d[i] = valid_q[i-1];
      if (first_load) res_d[FIRST] = first_res;
      for (int i = FIRST + 1; i < LATENCY; i++) begin
        if (valid_q[i-1]) res_d[i] = res_q[i-1];
      end
    end
  end

  // Stage valid bits and finished results; reset discards everything in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < LATENCY; i++) res_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < LATENCY; i++) res_q[i] <= res_d[i];
    end
  end

  assign out_valid = valid_q[LATENCY-1];
  assign {diff, bout, zero, neg, ovf, lts} = res_q[LATENCY-1];

`ifdef SUB_PIPE_OCC_EN
  logic       drain;
  logic [3:0] occ_d, occ_q;

  assign drain = valid_q[LATENCY-1] && out_ready;

  // Count ops in flight: up on accept alone, down on drain alone, otherwise hold
  always_comb begin
    occ_d = occ_q;
    if (accept && !drain)      occ_d = occ_q + 4'd1;
    else if (!accept && drain) occ_d = occ_q - 4'd1;
  end

  // Occupancy counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) occ_q <= 4'd0;
    else       occ_q <= occ_d;
  end

  assign occ = occ_q;

  // There are only LATENCY slots, so occupancy can never exceed it
  assert property (@(posedge clk) disable iff (reset) occ_q <= 4'(LATENCY));
`endif

endmodule

// File: tb/tb_sub_pipe32.sv
// Testbench for sub_pipe32: directed arithmetic cases plus randomized streams
// with bubbles and backpressure. A queue-based reference model computes the
// expected results from plain arithmetic.
module tb_sub_pipe32;

  localparam int WIDTH   = 32;
  localparam int LATENCY = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  x, y;
  logic              bin;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  diff;
  logic              bout, zero, neg, ovf, lts;
  logic [4:0]        dutFlags;
`ifdef SUB_PIPE_OCC_EN
  logic [3:0]        occ;
`endif

  typedef struct {
    logic [31:0] d;
    logic [4:0]  f;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;
  bit   exactLat = 1'b1;

  sub_pipe32 #(.WIDTH(WIDTH), .LATENCY(LATENCY)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .zero      (zero),
    .neg       (neg),
    .ovf       (ovf),
`ifdef SUB_PIPE_OCC_EN
    .occ       (occ),
`endif
    .lts       (lts)
  );

  assign dutFlags = {bout, zero, neg, ovf, lts};

  // 100 MHz clock
  initial forever #5 clk = ~clk;

  // Count rising edges so that latency can be measured
  initial forever begin
    @(posedge clk);
    cycle++;
  end

  // Give up if something hangs
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: the difference is x - y - bin, the borrow is x < y + bin,
  // and lts is the signed comparison (neg ^ ovf when bin is set).
  function automatic exp_t refModel(input logic [31:0] a, input logic [31:0] b,
                                    input logic c, input int acc);
    exp_t e;
    logic bo, ov, lt;
    e.d = a - b - 32'(c);
    bo  = ({1'b0, a} < ({1'b0, b} + 33'(c)));
    ov  = (a[31] != b[31]) && (e.d[31] != a[31]);
    lt  = (c == 1'b0) ? ($signed(a) < $signed(b)) : (e.d[31] ^ ov);
    e.f = {bo, (e.d == 32'd0), e.d[31], ov, lt};
    e.acc = acc;
    return e;
  endfunction

  // Drive one cycle of inputs; returns 1 ns after the next rising edge
  task automatic applyStimulus(input logic v, input logic [31:0] xv, input logic [31:0] yv,
                               input logic bv, input logic ordy);
    in_valid  = v;
    x         = v ? xv : $urandom;
    y         = v ? yv : $urandom;
    bin       = v ? bv : 1'($urandom);
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic randomOp(input logic ordy);
    applyStimulus(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), ordy);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 200; i++) begin
      if (q.size() == 0) break;
      idle();
    end
    checkOutput("drain_timeout", 64'(q.size()), 64'd0);
    exactLat = 1'b1;
  endtask

  // Single op into an empty pipe: out_valid must stay low for LATENCY-1 cycles, then rise with the constant result
  task automatic runDirected(input string tag, input logic [31:0] xv, input logic [31:0] yv,
                             input logic bv, input logic [31:0] expD, input logic [4:0] expF);
    applyStimulus(1'b1, xv, yv, bv, 1'b1);
    checkOutput({tag, "_early"}, 64'(out_valid), 64'd0);
    for (int k = 1; k < LATENCY - 1; k++) begin
      idle();
      checkOutput({tag, "_early"}, 64'(out_valid), 64'd0);
    end
    idle();
    checkOutput({tag, "_valid"}, 64'(out_valid), 64'd1);
    checkOutput({tag, "_diff"},  64'(diff), 64'(expD));
    checkOutput({tag, "_flags"}, 64'(dutFlags), 64'(expF));
  endtask

  // Scoreboard on the falling edge: check handshake, holding, results and latency
  initial begin
    exp_t        e;
    int          lat;
    bit          held = 1'b0;
    logic [31:0] heldDiff;
    logic [4:0]  heldFlags;
    forever begin
      @(negedge clk);
      if (reset) begin
        q.delete();
        held = 1'b0;
        checkOutput("rst_valid", 64'(out_valid), 64'd0);
      end else begin
        checkOutput("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
`ifdef SUB_PIPE_OCC_EN
        checkOutput("occ", 64'(occ), 64'(q.size()));
`endif
        if (held) begin
          checkOutput("hold_valid", 64'(out_valid), 64'd1);
          checkOutput("hold_diff",  64'(diff), 64'(heldDiff));
          checkOutput("hold_flags", 64'(dutFlags), 64'(heldFlags));
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            checkOutput("spurious_result", 64'd1, 64'd0);
          end else begin
            e = q.pop_front();
            checkOutput("diff",  64'(diff), 64'(e.d));
            checkOutput("flags", 64'(dutFlags), 64'(e.f));
            lat = cycle - e.acc;
            if (exactLat) checkOutput("latency", 64'(lat), 64'(LATENCY));
            else          checkOutput("latency_min", 64'(lat >= LATENCY), 64'd1);
          end
        end
        if (in_valid && in_ready) q.push_back(refModel(x, y, bin, cycle));
        held      = out_valid && !out_ready;
        heldDiff  = diff;
        heldFlags = dutFlags;
      end
    end
  end

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; x = '0; y = '0; bin = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_diff",      64'(diff), 64'd0);
    checkOutput("rst_flags",     64'(dutFlags), 64'd0);
    reset = 1'b0;
    #1;
    checkOutput("rst_in_ready",  64'(in_ready), 64'd1);
    idle();

    $display("[TB] directed arithmetic");
    runDirected("sub5_3",  32'd5, 32'd3, 1'b0, 32'd2,        5'b00000);
    runDirected("borrow",  32'd0, 32'd1, 1'b0, 32'hFFFFFFFF, 5'b10101);
    runDirected("zero",    32'd7, 32'd6, 1'b1, 32'd0,        5'b01000);
    runDirected("ovf_neg", 32'h80000000, 32'd1, 1'b0, 32'h7FFFFFFF, 5'b00011);
    runDirected("ovf_pos", 32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 5'b10110);
    waitDrain();

    $display("[TB] back-to-back stream");
    for (int i = 0; i < 20; i++) randomOp(1'b1);
    waitDrain();

    $display("[TB] stream with bubbles");
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) != 0) randomOp(1'b1);
      else idle();
    end
    waitDrain();

    $display("[TB] backpressure");
    for (int i = 0; i < 8; i++) randomOp(1'b1);
    exactLat = 1'b0;
    for (int i = 0; i < 6; i++) begin
      randomOp(1'b0);
      checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
`ifdef SUB_PIPE_OCC_EN
      checkOutput("bp_occ_peak", 64'(occ), 64'(LATENCY));
`endif
    end
    waitDrain();

    $display("[TB] random traffic with random stalls");
    exactLat = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) != 0) randomOp(1'($urandom_range(0, 3) != 0));
      else applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'($urandom_range(0, 3) != 0));
    end
    waitDrain();

    $display("[TB] reset mid-flight");
    for (int i = 0; i < 3; i++) randomOp(1'b1);
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    runDirected("post_rst", 32'd100, 32'd58, 1'b0, 32'd42, 5'b00000);
    waitDrain();

    $display("[TB] reset while output held");
    for (int i = 0; i < 7; i++) randomOp(1'b0);
    checkOutput("full_valid", 64'(out_valid), 64'd1);
    reset = 1'b1;
    #1;
    checkOutput("async_rst_valid", 64'(out_valid), 64'd0);
    checkOutput("async_rst_diff",  64'(diff), 64'd0);
    checkOutput("async_rst_flags", 64'(dutFlags), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < LATENCY + 2; i++) begin
      idle();
      checkOutput("after_rst_quiet", 64'(out_valid), 64'd0);
    end
    waitDrain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
